// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_pkg
// Brief    : Shared state encoding and helpers for the code_lock controller.
// Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    UNLOCK  = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Brief    : Shared saturating counter with clear/load/inc/dec and compares.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer
  import code_lock_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int EXPIRE_AT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic             o_is_one,
  output logic             o_expire
);

  localparam logic [WIDTH-1:0] c_one    = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_expire = WIDTH'(EXPIRE_AT);

  logic [WIDTH-1:0] r_count;

  // Clear wins over load, load over counting; both directions saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + c_one;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - c_one;
    end
  end

  assign o_is_one = (r_count == c_one);
  assign o_expire = (r_count == c_expire);

endmodule
`default_nettype wire

// File: rtl/code_lock.sv
`default_nettype none
// ============================================================================
// Module   : code_lock
// Brief    : N-symbol sequence lock with timed unlock, entry timeout and
//            brute-force lockout.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock #(
  parameter int W           = 4,
  parameter int N           = 4,
  parameter int UNLOCK_CYC  = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int TIMEOUT     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [W-1:0]           i_sym,
  input  logic [N*W-1:0]         i_code,
  output logic                   o_unlock,
  output logic                   o_locked_out,
  output logic                   o_fail,
  output logic [$clog2(N+1)-1:0] o_progress
);
  import code_lock_pkg::*;

  localparam int IW = $clog2(N + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(max3(UNLOCK_CYC, LOCKOUT_CYC, TIMEOUT) + 1);

  localparam logic [IW-1:0] c_idx_last  = IW'(N - 1);
  localparam logic [IW-1:0] c_idx_one   = IW'(1);
  localparam logic [FW-1:0] c_fail_last = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] c_fail_one  = FW'(1);
  localparam logic [TW-1:0] c_unlock_ld = TW'(UNLOCK_CYC);
  localparam logic [TW-1:0] c_lock_ld   = TW'(LOCKOUT_CYC);

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [FW-1:0] r_fail_cnt;
  logic          r_unlock;
  logic          r_locked_out;
  logic          r_fail;

  logic [W-1:0]  w_exp_sym;
  logic          w_match;
  logic          w_last;
  logic          w_fail_last;
  logic          w_t_clr;
  logic          w_t_load;
  logic [TW-1:0] w_t_load_val;
  logic          w_t_inc;
  logic          w_t_dec;
  logic          w_t_is_one;
  logic          w_t_expire;

  assign w_exp_sym   = i_code[int'(r_idx)*W +: W];
  assign w_match     = (i_sym == w_exp_sym);
  assign w_last      = (r_idx == c_idx_last);
  assign w_fail_last = (r_fail_cnt == c_fail_last);

  // One counter serves entry timeout, unlock hold and lockout hold.
  always_comb begin
    w_t_clr      = 1'b0;
    w_t_load     = 1'b0;
    w_t_load_val = '0;
    w_t_inc      = 1'b0;
    w_t_dec      = 1'b0;
    case (r_state)
      ENTRY: begin
        if (i_valid) begin
          if (w_match && w_last) begin
            w_t_load     = 1'b1;
            w_t_load_val = c_unlock_ld;
          end else if (!w_match && w_fail_last) begin
            w_t_load     = 1'b1;
            w_t_load_val = c_lock_ld;
          end else begin
            w_t_clr = 1'b1;
          end
        end else if (r_idx != '0) begin
          if (w_t_expire) w_t_clr = 1'b1;
          else            w_t_inc = 1'b1;
        end
      end
      UNLOCK, LOCKOUT: begin
        if (w_t_is_one) w_t_clr = 1'b1;
        else            w_t_dec = 1'b1;
      end
      default: w_t_clr = 1'b1;
    endcase
  end

  cycle_timer #(
    .WIDTH     (TW),
    .EXPIRE_AT (TIMEOUT - 1)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_t_clr),
    .i_load     (w_t_load),
    .i_load_val (w_t_load_val),
    .i_inc      (w_t_inc),
    .i_dec      (w_t_dec),
    .o_is_one   (w_t_is_one),
    .o_expire   (w_t_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ENTRY;
      r_idx        <= '0;
      r_fail_cnt   <= '0;
      r_unlock     <= 1'b0;
      r_locked_out <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_fail <= 1'b0;
      case (r_state)
        ENTRY: begin
          if (i_valid) begin
            if (w_match) begin
              if (w_last) begin
                r_state    <= UNLOCK;
                r_idx      <= '0;
                r_fail_cnt <= '0;
                r_unlock   <= 1'b1;
              end else begin
                r_idx <= r_idx + c_idx_one;
              end
            end else begin
              // The mismatching symbol is discarded, never retried as symbol 0.
              r_idx  <= '0;
              r_fail <= 1'b1;
              if (w_fail_last) begin
                r_state      <= LOCKOUT;
                r_fail_cnt   <= '0;
                r_locked_out <= 1'b1;
              end else begin
                r_fail_cnt <= r_fail_cnt + c_fail_one;
              end
            end
          end else if ((r_idx != '0) && w_t_expire) begin
            r_idx <= '0;
          end
        end
        UNLOCK, LOCKOUT: begin
          if (w_t_is_one) begin
            r_state      <= ENTRY;
            r_idx        <= '0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
          end
        end
        default: begin
          r_state      <= ENTRY;
          r_idx        <= '0;
          r_unlock     <= 1'b0;
          r_locked_out <= 1'b0;
        end
      endcase
    end
  end

  assign o_unlock     = r_unlock;
  assign o_locked_out = r_locked_out;
  assign o_fail       = r_fail;
  assign o_progress   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_code_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock
// Brief    : Directed self-checking bench for code_lock (default and N=1 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock;

  typedef struct packed {
    logic       u;
    logic       lo;
    logic       f;
    logic [2:0] p;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        v1;
  logic [3:0]  s1;
  logic [15:0] code1 = 16'hC5A3;
  logic        u1, lo1, f1;
  logic [2:0]  p1;

  logic        v2;
  logic [7:0]  s2;
  logic [7:0]  code2 = 8'h5A;
  logic        u2, lo2, f2;
  logic [0:0]  p2;

  exp_t  q1[$];
  exp_t  q2[$];
  int    n_cmp  = 0;
  int    n_err  = 0;
  int    stepno = 0;
  string phase  = "init";

  always #5 clk = ~clk;

  code_lock dut1 (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (v1),
    .i_sym        (s1),
    .i_code       (code1),
    .o_unlock     (u1),
    .o_locked_out (lo1),
    .o_fail       (f1),
    .o_progress   (p1)
  );

  code_lock #(
    .W           (8),
    .N           (1),
    .UNLOCK_CYC  (1),
    .MAX_FAIL    (1),
    .LOCKOUT_CYC (4),
    .TIMEOUT     (8)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (v2),
    .i_sym        (s2),
    .i_code       (code2),
    .o_unlock     (u2),
    .o_locked_out (lo2),
    .o_fail       (f2),
    .o_progress   (p2)
  );

  task automatic chk1();
    exp_t e;
    e = q1.pop_front();
    n_cmp += 4;
    assert (u1 === e.u) else begin n_err++; $error("FAIL %s#%0d unlock: got %b want %b", phase, stepno, u1, e.u); end
    assert (lo1 === e.lo) else begin n_err++; $error("FAIL %s#%0d locked_out: got %b want %b", phase, stepno, lo1, e.lo); end
    assert (f1 === e.f) else begin n_err++; $error("FAIL %s#%0d fail: got %b want %b", phase, stepno, f1, e.f); end
    assert (p1 === e.p) else begin n_err++; $error("FAIL %s#%0d progress: got %0d want %0d", phase, stepno, p1, e.p); end
  endtask

  task automatic chk2();
    exp_t e;
    e = q2.pop_front();
    n_cmp += 4;
    assert (u2 === e.u) else begin n_err++; $error("FAIL %s#%0d unlock: got %b want %b", phase, stepno, u2, e.u); end
    assert (lo2 === e.lo) else begin n_err++; $error("FAIL %s#%0d locked_out: got %b want %b", phase, stepno, lo2, e.lo); end
    assert (f2 === e.f) else begin n_err++; $error("FAIL %s#%0d fail: got %b want %b", phase, stepno, f2, e.f); end
    assert (p2 === e.p[0:0]) else begin n_err++; $error("FAIL %s#%0d progress: got %0d want %0d", phase, stepno, p2, e.p); end
  endtask

  // Drive one cycle on dut1 and state what its outputs must be after the edge.
  task automatic s(input logic v, input logic [3:0] sy,
                   input logic eu, input logic el, input logic ef, input int ep);
    v1 = v; s1 = sy; v2 = 1'b0; s2 = '0;
    q1.push_back('{u: eu, lo: el, f: ef, p: 3'(ep)});
    @(posedge clk); #1;
    stepno++;
    chk1();
  endtask

  task automatic t2(input logic v, input logic [7:0] sy,
                    input logic eu, input logic el, input logic ef);
    v2 = v; s2 = sy; v1 = 1'b0; s1 = '0;
    q2.push_back('{u: eu, lo: el, f: ef, p: 3'd0});
    @(posedge clk); #1;
    stepno++;
    chk2();
  endtask

  task automatic idle(input int n, input logic eu, input logic el, input int ep);
    for (int k = 0; k < n; k++) s(1'b0, 4'h0, eu, el, 1'b0, ep);
  endtask

  // Full correct code followed by the complete 4-cycle unlock window.
  task automatic enter_ok();
    s(1'b1, 4'h3, 0, 0, 0, 1);
    s(1'b1, 4'hA, 0, 0, 0, 2);
    s(1'b1, 4'h5, 0, 0, 0, 3);
    s(1'b1, 4'hC, 1, 0, 0, 0);
    idle(3, 1, 0, 0);
    idle(1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; v1 = 1'b0; s1 = '0; v2 = 1'b0; s2 = '0;

    phase = "reset";
    s(1'b0, 4'h0, 0, 0, 0, 0);
    t2(1'b0, 8'h00, 0, 0, 0);
    reset = 1'b0;

    phase = "correct";
    enter_ok();

    phase = "mismatch";
    s(1'b1, 4'h3, 0, 0, 0, 1);
    s(1'b1, 4'hA, 0, 0, 0, 2);
    s(1'b1, 4'h7, 0, 0, 1, 0);
    idle(1, 0, 0, 0);
    enter_ok();
    s(1'b1, 4'h0, 0, 0, 1, 0);
    s(1'b1, 4'h0, 0, 0, 1, 0);
    idle(1, 0, 0, 0);
    enter_ok();

    phase = "lockout";
    s(1'b1, 4'h1, 0, 0, 1, 0);
    s(1'b1, 4'h1, 0, 0, 1, 0);
    s(1'b1, 4'h1, 0, 1, 1, 0);
    s(1'b1, 4'h3, 0, 1, 0, 0);
    s(1'b1, 4'hA, 0, 1, 0, 0);
    s(1'b1, 4'h5, 0, 1, 0, 0);
    s(1'b1, 4'hC, 0, 1, 0, 0);
    idle(11, 0, 1, 0);
    idle(1, 0, 0, 0);
    enter_ok();

    phase = "timeout";
    s(1'b1, 4'h3, 0, 0, 0, 1);
    s(1'b1, 4'hA, 0, 0, 0, 2);
    idle(7, 0, 0, 2);
    idle(1, 0, 0, 0);
    s(1'b1, 4'h3, 0, 0, 0, 1);
    s(1'b1, 4'hA, 0, 0, 0, 2);
    idle(7, 0, 0, 2);
    s(1'b1, 4'h5, 0, 0, 0, 3);
    s(1'b1, 4'hC, 1, 0, 0, 0);
    idle(3, 1, 0, 0);
    idle(1, 0, 0, 0);

    phase = "reset_mid";
    s(1'b1, 4'h3, 0, 0, 0, 1);
    s(1'b1, 4'hA, 0, 0, 0, 2);
    s(1'b1, 4'h5, 0, 0, 0, 3);
    s(1'b1, 4'hC, 1, 0, 0, 0);
    idle(1, 1, 0, 0);
    reset = 1'b1;
    s(1'b1, 4'h9, 0, 0, 0, 0);
    reset = 1'b0;
    s(1'b1, 4'h0, 0, 0, 1, 0);
    s(1'b1, 4'h0, 0, 0, 1, 0);
    s(1'b1, 4'h3, 0, 0, 0, 1);
    s(1'b1, 4'hA, 0, 0, 0, 2);
    s(1'b1, 4'h5, 0, 0, 0, 3);
    reset = 1'b1;
    s(1'b0, 4'h0, 0, 0, 0, 0);
    reset = 1'b0;
    s(1'b1, 4'h0, 0, 0, 1, 0);
    s(1'b1, 4'h0, 0, 0, 1, 0);
    idle(1, 0, 0, 0);

    phase = "sweep";
    t2(1'b1, 8'h5A, 1, 0, 0);
    t2(1'b0, 8'h00, 0, 0, 0);
    t2(1'b1, 8'h11, 0, 1, 1);
    for (int k = 0; k < 3; k++) t2(1'b1, 8'h5A, 0, 1, 0);
    t2(1'b0, 8'h00, 0, 0, 0);
    t2(1'b1, 8'h5A, 1, 0, 0);
    t2(1'b0, 8'h00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
